// File: rtl/button_debouncer_pkg.sv
// Shared board constants and helpers for the push-button front end.
// Clock rate, debounce interval and the button index map are also used
// by the LED counter that consumes the debounced outputs.
package button_debouncer_pkg;

  localparam int unsigned CLK_HZ      = 12_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;

  // Which pmod button drives which function downstream.
  localparam int unsigned BTN_RESET = 0;
  localparam int unsigned BTN_STEP  = 1;
  localparam int unsigned BTN_AUX0  = 2;
  localparam int unsigned BTN_AUX1  = 3;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  // Counter must hold values up to DEBOUNCE_CYCLES.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);

endpackage

// File: rtl/button_debouncer_if.sv
// Bundle of raw button pins and the conditioned outputs.
// master: the board/bench side that drives pins and observes results.
// slave:  the debouncer that consumes pins and produces results.
interface button_debouncer_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] pmod;
  logic [WIDTH-1:0] btn_level;
  logic [WIDTH-1:0] btn_press;
  logic [WIDTH-1:0] btn_release;

  modport master (
    output pmod,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  pmod,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/button_debouncer_channel.sv
// One button: 2-FF synchronizer, restart-on-glitch counter filter, edge pulses.
// Level changes N+1 edges after a pin change lands in the first sync flop.
// Press/release pulses are registered and last exactly one cycle.
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned        CNT_W        = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Raw pin value that means "not pressed"; sync flops start here so reset
  // does not look like a press.
  localparam logic               RELEASED_PIN = ACTIVE_LOW;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             p;

  // Next-state: synchronize, count consecutive mismatches, accept after N.
  always_comb begin
    s1_d      = pin;
    s2_d      = s1_q;
    p         = s2_q ^ ACTIVE_LOW;
    stable_d  = stable_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (p != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d  = p;
        press_d   = p;
        release_d = ~p;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset drops any count in progress without pulsing.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q      <= RELEASED_PIN;
      s2_q      <= RELEASED_PIN;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces WIDTH independent raw pmod buttons into level/press/release.
// Level latency is DEBOUNCE_CYCLES+1 edges after a pin change is first sampled.
// No backpressure: pulses are single-cycle and must be consumed when seen.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  button_debouncer_if.slave  bus
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] rel;

  // One fully independent filter per button.
  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .pin       (bus.pmod[g]),
      .level_o   (level[g]),
      .press_o   (press[g]),
      .release_o (rel[g])
    );
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios with literal expectations,
// then random pin activity, all compared each cycle to a window-based model.
module tb_button_debouncer;

  localparam int W  = 4;
  localparam int N  = 8;
  localparam bit AL = 1'b1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  button_debouncer_if #(.WIDTH(W)) bus ();

  button_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (N),
    .ACTIVE_LOW      (AL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  bit done         = 1'b0;

  // Model: a channel flips exactly when the last N pressed-polarity samples
  // seen by the filter (pin samples 2..N+1 edges old) all disagree with it.
  logic [W-1:0] hist [0:N];
  logic [W-1:0] m_level, m_press, m_rel;
  bit           m_valid = 1'b0;

  always @(posedge clock) begin
    logic [W-1:0] acc;
    if (reset) begin
      for (int j = 0; j <= N; j++) hist[j] = '0;
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
    end else begin
      acc = '1;
      for (int j = 1; j <= N; j++) acc = acc & (hist[j] ^ m_level);
      m_press = acc & ~m_level;
      m_rel   = acc & m_level;
      m_level = m_level ^ acc;
      for (int j = N; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = bus.pmod ^ {W{AL}};
    end
    m_valid = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clock);
  endtask

  int pulses, rels, at;

  initial begin
    reset    = 1'b1;
    bus.pmod = '1;
    fork
      begin : compare
        while (!done) begin
          @(negedge clock);
          if (!done && m_valid) begin
            check("model_level",   bus.btn_level,   m_level);
            check("model_press",   bus.btn_press,   m_press);
            check("model_release", bus.btn_release, m_rel);
            check("press_release_excl", bus.btn_press & bus.btn_release, 0);
          end
        end
      end
      begin : stim
        // 1: reset state and quiet idle
        edges(3);
        check("rst_level",   bus.btn_level,   0);
        check("rst_press",   bus.btn_press,   0);
        check("rst_release", bus.btn_release, 0);
        reset = 1'b0;
        edges(50);
        check("idle_level", bus.btn_level, 0);
        check("idle_press", bus.btn_press, 0);

        // 2: single clean press on bit 0
        bus.pmod[0] = 1'b0;
        edges(9);
        check("s2_level_early", bus.btn_level, 4'b0000);
        edges(1);
        check("s2_level", bus.btn_level, 4'b0001);
        check("s2_press", bus.btn_press, 4'b0001);
        edges(1);
        check("s2_press_once", bus.btn_press, 4'b0000);
        check("s2_level_hold", bus.btn_level, 4'b0001);

        // 3: bit 1 bouncing every 3 cycles, then held pressed
        pulses = 0;
        for (int ph = 0; ph < 10; ph++) begin
          bus.pmod[1] = (ph % 2 == 1);
          for (int i = 0; i < 3; i++) begin
            edges(1);
            pulses += int'(bus.btn_press[1]);
          end
        end
        bus.pmod[1] = 1'b0;
        at = 0;
        for (int i = 1; i <= 20; i++) begin
          edges(1);
          if (bus.btn_press[1]) begin
            pulses++;
            at = i;
          end
        end
        check("s3_pulses", pulses, 1);
        check("s3_pulse_at", at, 10);

        // 4: bit 2 glitch of N-1 cycles is ignored, N cycles is accepted
        bus.pmod[2] = 1'b0;
        edges(7);
        bus.pmod[2] = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
          edges(1);
          pulses += int'(bus.btn_press[2]) + int'(bus.btn_level[2]);
        end
        check("s4_short_ignored", pulses, 0);
        bus.pmod[2] = 1'b0;
        edges(8);
        bus.pmod[2] = 1'b1;
        pulses = 0;
        rels   = 0;
        for (int i = 0; i < 30; i++) begin
          edges(1);
          pulses += int'(bus.btn_press[2]);
          rels   += int'(bus.btn_release[2]);
        end
        check("s4_press_count",   pulses, 1);
        check("s4_release_count", rels,   1);

        // 5: release bit 0 while pressing bits 3:2 on the same edge
        bus.pmod[0]   = 1'b1;
        bus.pmod[3:2] = 2'b00;
        edges(9);
        check("s5_level_early", bus.btn_level, 4'b0011);
        edges(1);
        check("s5_release", bus.btn_release, 4'b0001);
        check("s5_press",   bus.btn_press,   4'b1100);
        check("s5_level",   bus.btn_level,   4'b1110);

        // 6: reset in the middle of a bit-1 press count, button kept held
        bus.pmod[1] = 1'b1;
        edges(12);
        check("s6_released", bus.btn_level, 4'b1100);
        bus.pmod[1] = 1'b0;
        edges(7);
        reset = 1'b1;
        edges(2);
        check("s6_rst_level",   bus.btn_level,   0);
        check("s6_rst_press",   bus.btn_press,   0);
        check("s6_rst_release", bus.btn_release, 0);
        reset = 1'b0;
        edges(9);
        check("s6_press_early", bus.btn_press, 0);
        edges(1);
        check("s6_press", bus.btn_press, 4'b1110);
        check("s6_level", bus.btn_level, 4'b1110);

        // Random bouncing with occasional resets
        for (int cyc = 0; cyc < 4000; cyc++) begin
          edges(1);
          for (int c = 0; c < W; c++)
            if ($urandom_range(5) == 0) bus.pmod[c] = ~bus.pmod[c];
          reset = ($urandom_range(199) == 0);
        end
        reset = 1'b0;
        edges(20);
        done = 1'b1;
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
